// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared op encodings and FSM states for the iterative multiply/divide unit
package mdu_pkg;

    localparam int MDU_OP_W = 3;

    localparam logic [MDU_OP_W-1:0] MDU_MULT  = 3'b000;
    localparam logic [MDU_OP_W-1:0] MDU_MULTU = 3'b001;
    localparam logic [MDU_OP_W-1:0] MDU_DIV   = 3'b010;
    localparam logic [MDU_OP_W-1:0] MDU_DIVU  = 3'b011;
    localparam logic [MDU_OP_W-1:0] MDU_MTHI  = 3'b100;
    localparam logic [MDU_OP_W-1:0] MDU_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        FIX
    } mdu_state_e;

endpackage

// File: rtl/mdu_div_core.sv
// rtl/mdu_div_core.sv - unsigned radix-2 restoring divider, one quotient bit per step, MSB first
module mdu_div_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             step_en,
    input  logic             clear,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             last
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvsr_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             fits;

    // quo_q starts as the dividend and shifts its bits into the partial remainder
    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        fits    = shifted >= {1'b0, dvsr_q};
        diff    = shifted[WIDTH-1:0] - dvsr_q;
    end

    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvsr_q <= '0;
            cnt_q  <= '0;
        end else if (start) begin
            rem_q  <= '0;
            quo_q  <= dividend;
            dvsr_q <= divisor;
            cnt_q  <= '0;
        end else if (step_en) begin
            rem_q  <= fits ? diff : shifted[WIDTH-1:0];
            quo_q  <= {quo_q[WIDTH-2:0], fits};
            cnt_q  <= cnt_q + CW'(1);
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign last      = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative multiply/divide unit owning HI/LO, with flush cancel
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MUL_ITER = 0
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_src1,
    input  logic [WIDTH-1:0] req_src2,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    mdu_state_e state_q, state_d;

    logic               accept;
    logic               is_signed;
    logic               src1_neg;
    logic               src2_neg;
    logic [WIDTH-1:0]   src1_mag;
    logic [WIDTH-1:0]   src2_mag;
    logic [2*WIDTH-1:0] fast_mag;
    logic [2*WIDTH-1:0] fast_prod;

    logic               neg_res_q;
    logic               rem_neg_q;
    logic               div_zero_q;
    logic [WIDTH-1:0]   src1_q;

    logic [2*WIDTH-1:0] mul_acc_q;
    logic [2*WIDTH-1:0] mul_mcand_q;
    logic [WIDTH-1:0]   mul_mplier_q;
    logic [CW-1:0]      mul_cnt_q;
    logic [2*WIDTH-1:0] mul_sum;
    logic [2*WIDTH-1:0] mul_res;
    logic               mul_last;

    logic               div_start;
    logic               div_step;
    logic               div_clear;
    logic               div_last;
    logic [WIDTH-1:0]   div_quo;
    logic [WIDTH-1:0]   div_rem;

    // Both multiply flavours work on magnitudes and fix the sign at the end
    always_comb begin
        is_signed = (req_op == MDU_MULT) || (req_op == MDU_DIV);
        src1_neg  = is_signed && req_src1[WIDTH-1];
        src2_neg  = is_signed && req_src2[WIDTH-1];
        src1_mag  = src1_neg ? -req_src1 : req_src1;
        src2_mag  = src2_neg ? -req_src2 : req_src2;
        fast_mag  = {{WIDTH{1'b0}}, src1_mag} * {{WIDTH{1'b0}}, src2_mag};
        fast_prod = (src1_neg ^ src2_neg) ? -fast_mag : fast_mag;
        mul_sum   = mul_acc_q + (mul_mplier_q[0] ? mul_mcand_q : '0);
        mul_res   = neg_res_q ? -mul_sum : mul_sum;
        mul_last  = (mul_cnt_q == CW'(WIDTH - 1));
    end

    always_comb begin
        req_ready = (state_q == IDLE) && !cancel;
        accept    = req_valid && req_ready;
        busy      = (state_q != IDLE);
        state_d   = state_q;
        div_start = 1'b0;
        div_step  = 1'b0;
        div_clear = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if ((req_op == MDU_MULT || req_op == MDU_MULTU) && MUL_ITER != 0) begin
                        state_d = MUL;
                    end else if (req_op == MDU_DIV || req_op == MDU_DIVU) begin
                        state_d   = DIV;
                        div_start = 1'b1;
                    end
                end
            end
            MUL: begin
                if (cancel || mul_last) state_d = IDLE;
            end
            DIV: begin
                if (cancel) begin
                    state_d   = IDLE;
                    div_clear = 1'b1;
                end else begin
                    div_step = 1'b1;
                    if (div_last) state_d = FIX;
                end
            end
            FIX: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            hi           <= '0;
            lo           <= '0;
            done         <= 1'b0;
            neg_res_q    <= 1'b0;
            rem_neg_q    <= 1'b0;
            div_zero_q   <= 1'b0;
            src1_q       <= '0;
            mul_acc_q    <= '0;
            mul_mcand_q  <= '0;
            mul_mplier_q <= '0;
            mul_cnt_q    <= '0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                neg_res_q <= src1_neg ^ src2_neg;
                case (req_op)
                    MDU_MTHI: hi <= req_src1;
                    MDU_MTLO: lo <= req_src1;
                    MDU_MULT, MDU_MULTU: begin
                        if (MUL_ITER == 0) begin
                            {hi, lo} <= fast_prod;
                            done     <= 1'b1;
                        end else begin
                            mul_acc_q    <= '0;
                            mul_mcand_q  <= {{WIDTH{1'b0}}, src1_mag};
                            mul_mplier_q <= src2_mag;
                            mul_cnt_q    <= '0;
                        end
                    end
                    MDU_DIV, MDU_DIVU: begin
                        rem_neg_q  <= src1_neg;
                        div_zero_q <= (req_src2 == '0);
                        src1_q     <= req_src1;
                    end
                    default: ;
                endcase
            end
            // The final partial product is folded in on the write cycle itself
            if (state_q == MUL && !cancel) begin
                if (mul_last) begin
                    {hi, lo} <= mul_res;
                    done     <= 1'b1;
                end else begin
                    mul_acc_q    <= mul_sum;
                    mul_mcand_q  <= mul_mcand_q << 1;
                    mul_mplier_q <= mul_mplier_q >> 1;
                    mul_cnt_q    <= mul_cnt_q + CW'(1);
                end
            end
            if (state_q == FIX && !cancel) begin
                lo   <= div_zero_q ? '1 : (neg_res_q ? -div_quo : div_quo);
                hi   <= div_zero_q ? src1_q : (rem_neg_q ? -div_rem : div_rem);
                done <= 1'b1;
            end
        end
    end

    mdu_div_core #(
        .WIDTH(WIDTH)
    ) u_div_core (
        .clk      (clk),
        .resetn   (resetn),
        .start    (div_start),
        .step_en  (div_step),
        .clear    (div_clear),
        .dividend (src1_mag),
        .divisor  (src2_mag),
        .quotient (div_quo),
        .remainder(div_rem),
        .last     (div_last)
    );

endmodule

// File: doc/mdu_iter.md
# mdu_iter

Parametrised iterative multiply/divide unit owning the HI/LO register pair for the execute stage. It accepts one MULT/MULTU/DIV/DIVU/MTHI/MTLO request at a time over a valid/ready handshake. Divides run as a WIDTH-step radix-2 restoring loop, and multiplies run either single-cycle or as a WIDTH-step shift-add. A cancel input lets the pipeline abort an in-flight operation on flush without disturbing HI/LO.

## Interface
- WIDTH, 32, operand and HI/LO width (≥ 8).
- MUL_ITER, 0, 0 = single-cycle multiply; 1 = iterative shift-add multiply.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  reset, synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept this cycle.
- req_op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 reserved.
- req_src1  in  WIDTH  rs: multiplicand, dividend, or MTHI/MTLO data.
- req_src2  in  WIDTH  rt: multiplier or divisor.
- cancel  in  1  abort in-flight operation.
- busy  out  1  multi-cycle operation in progress.
- done  out  1  one-cycle pulse; HI/LO hold the new result in this cycle.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

## Operation
- FSM states:
  - IDLE.
  - MUL: iterative multiply only.
  - DIV: WIDTH iterations.
  - FIX: sign correction and HI/LO write.
- req_ready = (state == IDLE) && !cancel. A request is accepted on an edge where req_valid && req_ready; operands are latched at accept.
- MTHI/MTLO: hi (resp. lo) <= req_src1 on the accept edge. No done pulse; the FSM stays in IDLE.
- Reserved ops: accepted and ignored, with no state change and no done.
- MULT/MULTU, MUL_ITER=0: {hi,lo} <= product on the accept edge.
- MULT/MULTU, MUL_ITER=1: go to MUL. Shift-add on operand magnitudes for WIDTH cycles, then {hi,lo} <= product, negated when signed and the operand signs differ.
- DIV/DIVU: go to DIV and divide magnitudes, one quotient bit per cycle, MSB first. Then go to FIX, which writes lo <= quotient and hi <= remainder.
  - Signed: the quotient is negated iff the operand signs differ; the remainder takes the dividend's sign.
- Division by zero (either signedness): lo = all-ones, hi = req_src1 unchanged. Latency is the full normal divide latency.
- Signed MIN / −1: lo = MIN, hi = 0 (2's-complement wrap). No trap.
- Product width: 2·WIDTH bits with no truncation; hi = upper WIDTH bits, lo = lower WIDTH bits.
- busy = state ∈ {MUL, DIV, FIX}.
- cancel while busy: next state is IDLE, HI/LO are unchanged, and done is not asserted. cancel in IDLE blocks acceptance only.
- Reset values: state IDLE; hi = lo = 0; done = 0; busy = 0; req_ready = 1 from the first cycle after reset release.
- Reset asserted mid-operation: abort, with the same values as reset.

## Timing
Let T be the accept cycle.
- MUL_ITER=0 multiply: done = 1 in T+1; new hi/lo visible in T+1; req_ready = 1 in T+1.
- MUL_ITER=1 multiply: MUL state in T+1 … T+WIDTH; done in T+WIDTH+1.
- Divide: DIV state in T+1 … T+WIDTH; FIX in T+WIDTH+1; done and new hi/lo in T+WIDTH+2 (T+34 for WIDTH=32).
- Back-to-back requests: the next request can be accepted in the done cycle.
- MTHI/MTLO: value visible in T+1; the next request can be accepted in T+1.
- cancel sampled in cycle C while busy: state IDLE and req_ready = 1 in C+1.
- cancel in the FIX cycle: the write is suppressed.
- hi/lo outputs come straight from registers, with no combinational path from req_* to them.

## Structure
- Shared package mdu_pkg:
  - op encoding localparams (MDU_MULT … MDU_MTLO);
  - state enum (IDLE, MUL, DIV, FIX);
  - the op field width.
- Sub-module mdu_div_core: unsigned WIDTH-bit restoring divider datapath with partial remainder, quotient shift register and step counter. Interface: start, step enable, clear, quotient, remainder.
- The top level holds the FSM, sign handling, the multiplier, HI/LO and the handshake.

## Test plan
All cases use WIDTH=32.
- MULT, MUL_ITER=0: src1 = 0xFFFFFFFD (−3), src2 = 5 → done in T+1; hi = 0xFFFFFFFF, lo = 0xFFFFFFF1.
- DIV 7 / 0xFFFFFFFE (−2) → done exactly in T+34; lo = 0xFFFFFFFD, hi = 1. req_ready = 0 through T+33, then 1.
- DIVU 0xFFFFFFFF / 0x10 → lo = 0x0FFFFFFF, hi = 0xF.
- DIVU 5 / 0 → lo = 0xFFFFFFFF, hi = 5.
- DIV 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0.
- MTHI 0x12345678, then DIV with cancel in T+10 → no done, hi still 0x12345678, req_ready = 1 in T+11.
- resetn low in T+5 of a DIV → hi = lo = 0 and busy = 0 in the cycle after the reset edge.
- MUL_ITER=1 MULTU 0xFFFFFFFF × 0xFFFFFFFF → done in T+33; hi = 0xFFFFFFFE, lo = 0x00000001.
